inst_sram_responder: RTL and testbench
======================================

INST_SRAM_RESPONDER -- requirements
Module: inst_sram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter MAX_OUTSTANDING, default 2, range 1..4, maximum accepted but unanswered requests.
REQ-003 Parameter LATENCY, default 1, range 1..7, minimum cycles from address handshake to data_ok.
REQ-004 clk  input  1  single clock; all logic updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 inst_sram_req  input  1  initiator request valid.
REQ-007 inst_sram_wr  input  1  1 = write, 0 = read.
REQ-008 inst_sram_size  input  2  transfer size; stored, not used for data selection.
REQ-009 inst_sram_addr  input  32  byte address.
REQ-010 inst_sram_wstrb  input  4  byte enables for writes.
REQ-011 inst_sram_wdata  input  32  write data.
REQ-012 inst_sram_addr_ok  output  1  request accepted this cycle when req is also 1.
REQ-013 inst_sram_data_ok  output  1  one response returned this cycle.
REQ-014 inst_sram_rdata  output  32  read data; valid when data_ok is 1.
REQ-015 resp_stall  input  1  test control; 1 suppresses data_ok.
REQ-016 accept_block  input  1  test control; 1 forces addr_ok to 0.

Function
REQ-017 Handshake: request accepted exactly when inst_sram_req && inst_sram_addr_ok in the same cycle; at most one acceptance per cycle.
REQ-018 addr_ok = !reset && !accept_block && (count < MAX_OUTSTANDING || pop_this_cycle); combinational from count, pop and test inputs, never from req.
REQ-019 Word index = addr[ADDR_WIDTH+1:2]; upper address bits ignored (wrap-around, no error); addr[1:0] ignored.
REQ-020 Read at acceptance: memory word sampled at the handshake edge and stored in the outstanding queue entry.
REQ-021 Write at acceptance: bytes with wstrb[i]=1 updated at the handshake edge; wstrb=0 writes nothing but still produces a response.
REQ-022 Queue: in-order FIFO of MAX_OUTSTANDING entries {is_write, data, age}; age starts at 0 on acceptance, increments each cycle, saturates at 7.
REQ-023 Response: data_ok=1 when queue non-empty, head age >= LATENCY-1 at the start of the cycle (i.e. earliest data_ok is LATENCY cycles after the handshake cycle), and resp_stall=0; asserting data_ok pops the head.
REQ-024 Responses returned strictly in acceptance order; at most one data_ok per cycle.
REQ-025 rdata = head data for reads, 32'h0 for write responses; when data_ok=0, rdata holds its last driven value.
REQ-026 Simultaneous pop and push in one cycle: count unchanged, both take effect; acceptance permitted when full if the head pops that cycle.
REQ-027 Read following a write to the same word in a later cycle returns the written data (write visible the cycle after its handshake).
REQ-028 Count never exceeds MAX_OUTSTANDING and never underflows; data_ok never asserted when empty.
REQ-029 resp_stall held indefinitely: queue fills, addr_ok drops, no state lost; release resumes in order.

Reset
REQ-030 While reset=1: addr_ok=0, data_ok=0, rdata=32'h0, queue count=0, all entry ages=0.
REQ-031 Reset mid-operation discards all outstanding requests; no data_ok for them after reset deasserts.
REQ-032 Memory contents are not cleared by reset; writes accepted before reset persist.
REQ-033 First acceptance possible in the first cycle with reset=0.

Verification
REQ-034 LATENCY=1: write addr 0x10 wdata 0xDEADBEEF wstrb 4'hF, then read 0x10 -> write data_ok next cycle with rdata 0; read data_ok next cycle with rdata 0xDEADBEEF.
REQ-035 Byte write addr 0x20 wstrb 4'b0010 wdata 0x0000AB00 over word 0x11223344 -> later read returns 0x1122AB44.
REQ-036 MAX_OUTSTANDING=2, resp_stall=1, three back-to-back reads -> first two accepted, addr_ok=0 for third; release stall -> data_ok two consecutive cycles in order, third accepted on the first pop cycle.
REQ-037 LATENCY=3, read accepted in cycle N -> data_ok first in cycle N+3, not earlier.
REQ-038 Two reads outstanding, reset pulsed one cycle -> no data_ok afterward, addr_ok=0 during reset, 1 the cycle after.
REQ-039 ADDR_WIDTH=10: write 0x00001000 value 0x5A5A5A5A, read 0x00000000 -> returns 0x5A5A5A5A (wrap-around).

Source files
------------

// File: rtl/inst_sram_responder.sv
// Instruction-side SRAM-like responder: word-addressed backing memory, an
// in-order outstanding-request queue with a per-entry age counter, and test
// hooks to stall responses or refuse new requests.
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LATENCY         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        resp_stall,
    input  logic        accept_block
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AGE_W  = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(7);
    localparam logic [AGE_W-1:0] READY_AGE = AGE_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

    // One accepted-but-unanswered request; write entries carry no data.
    typedef struct packed {
        logic              is_write;
        logic [1:0]        size;
        logic [DATA_W-1:0] data;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t            q_q [MAX_OUTSTANDING];
    entry_t            q_d [MAX_OUTSTANDING];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Backing store; deliberately left out of reset so contents survive it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx_c;
    logic                  head_ready_c;
    logic                  pop_c;
    logic                  addr_ok_c;
    logic                  push_c;
    logic [DATA_W-1:0]     mem_word_c;
    logic [DATA_W-1:0]     mem_wdata_c;
    logic                  mem_we_c;
    logic [DATA_W-1:0]     head_data_c;
    logic [CNT_W-1:0]      push_slot_c;
    entry_t                new_entry_c;
    logic                  unused_addr_bits_c;

    // Upper address bits wrap and byte offset is ignored.
    assign word_idx_c         = inst_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits_c = ^{inst_sram_addr[31:ADDR_WIDTH+2], inst_sram_addr[1:0]};

    // Handshake: pop when the head is old enough, accept when a slot is (or becomes) free.
    always_comb begin
        head_ready_c = (count_q != '0) && (q_q[0].age >= READY_AGE);
        pop_c        = !reset && head_ready_c && !resp_stall;
        addr_ok_c    = !reset && !accept_block && ((count_q < CNT_MAX) || pop_c);
        push_c       = inst_sram_req && addr_ok_c;
    end

    // Memory read port and byte-merged write word for the accepted request.
    always_comb begin
        mem_word_c  = mem_q[word_idx_c];
        mem_wdata_c = mem_word_c;
        for (int b = 0; b < 4; b++) begin
            if (inst_sram_wstrb[b]) begin
                mem_wdata_c[8*b +: 8] = inst_sram_wdata[8*b +: 8];
            end
        end
        mem_we_c = push_c && inst_sram_wr && (inst_sram_wstrb != '0);
    end

    // Entry captured at the handshake edge: read data is the pre-edge word.
    always_comb begin
        new_entry_c          = '0;
        new_entry_c.is_write = inst_sram_wr;
        new_entry_c.size     = inst_sram_size;
        new_entry_c.data     = inst_sram_wr ? '0 : mem_word_c;
        new_entry_c.age      = '0;
    end

    // Queue next state: age everything, shift out the head on pop, append on push.
    always_comb begin
        q_d         = q_q;
        count_d     = count_q;
        push_slot_c = count_q - CNT_W'(pop_c);

        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (q_d[i].age != AGE_MAX) begin
                q_d[i].age = q_d[i].age + AGE_W'(1);
            end
        end

        if (pop_c) begin
            for (int i = 0; i + 1 < int'(MAX_OUTSTANDING); i++) begin
                q_d[i] = q_d[i+1];
            end
            q_d[MAX_OUTSTANDING-1] = '0;
        end

        if (push_c) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (CNT_W'(i) == push_slot_c) begin
                    q_d[i] = new_entry_c;
                end
            end
        end

        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Response data: head word for reads, zero for writes, otherwise hold.
    always_comb begin
        head_data_c = q_q[0].is_write ? '0 : q_q[0].data;
        rdata_d     = pop_c ? head_data_c : rdata_q;
    end

    // Handshake outputs are combinational from queue state and test controls.
    always_comb begin
        inst_sram_addr_ok = addr_ok_c;
        inst_sram_data_ok = pop_c;
        inst_sram_rdata   = reset ? '0 : rdata_d;
    end

    // Queue, count and held read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                q_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    // Memory write at the handshake edge; visible from the next cycle.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[word_idx_c] <= mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: directed vector table, a LATENCY=3 timing
// sequence on a second instance, and random traffic against a transaction model.
module tb_inst_sram_responder;

    localparam int AW  = 10;
    localparam int MO  = 2;
    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        stall;
    logic        block;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;

    logic        req_b;
    logic        wr_b;
    logic [31:0] addr_b;
    logic [31:0] wdata_b;
    logic        aok_b;
    logic        dok_b;
    logic [31:0] rdata_b;

    int n_cmp;
    int n_err;

    inst_sram_responder #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (rst),
        .inst_sram_req     (req),
        .inst_sram_wr      (wr),
        .inst_sram_size    (size),
        .inst_sram_addr    (addr),
        .inst_sram_wstrb   (strb),
        .inst_sram_wdata   (wdata),
        .inst_sram_addr_ok (aok),
        .inst_sram_data_ok (dok),
        .inst_sram_rdata   (rdata),
        .resp_stall        (stall),
        .accept_block      (block)
    );

    inst_sram_responder #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(2), .LATENCY(3)) dut_lat3 (
        .clk               (clk),
        .reset             (rst),
        .inst_sram_req     (req_b),
        .inst_sram_wr      (wr_b),
        .inst_sram_size    (2'd2),
        .inst_sram_addr    (addr_b),
        .inst_sram_wstrb   (4'hF),
        .inst_sram_wdata   (wdata_b),
        .inst_sram_addr_ok (aok_b),
        .inst_sram_data_ok (dok_b),
        .inst_sram_rdata   (rdata_b),
        .resp_stall        (1'b0),
        .accept_block      (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        stall;
        logic        block;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
    } vec_t;

    // Transaction-level model: pending responses tagged with acceptance cycle.
    typedef struct {
        logic        w;
        logic [31:0] d;
        int          t;
    } pend_t;

    logic [31:0] m_mem [0:(1<<AW)-1];
    pend_t       m_q[$];
    int          m_cyc;
    logic [31:0] m_last;
    logic        m_aok;
    logic        m_dok;
    logic [31:0] m_rd;

    function automatic vec_t mk(logic r, logic rq, logic w, logic [31:0] a, logic [3:0] s,
                                logic [31:0] d, logic st, logic bl, logic ea, logic ed,
                                logic [31:0] er);
        vec_t v;
        v.rst = r; v.req = rq; v.wr = w; v.addr = a; v.strb = s; v.wd = d;
        v.stall = st; v.block = bl; v.aok = ea; v.dok = ed; v.rd = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval(input vec_t v);
        if (v.rst) begin
            m_dok = 1'b0;
            m_aok = 1'b0;
            m_rd  = 32'h0;
        end else begin
            m_dok = (m_q.size() > 0) && (m_cyc - m_q[0].t >= LAT) && !v.stall;
            m_aok = !v.block && ((m_q.size() < MO) || m_dok);
            m_rd  = m_dok ? (m_q[0].w ? 32'h0 : m_q[0].d) : m_last;
        end
    endtask

    task automatic model_update(input vec_t v);
        int    idx;
        pend_t p;
        if (v.rst) begin
            m_q.delete();
            m_last = 32'h0;
        end else begin
            if (m_dok) begin
                m_last = m_rd;
                void'(m_q.pop_front());
            end
            if (v.req && m_aok) begin
                idx = int'(v.addr[AW+1:2]);
                p.w = v.wr;
                p.t = m_cyc;
                p.d = 32'h0;
                if (v.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (v.strb[b]) m_mem[idx][8*b +: 8] = v.wd[8*b +: 8];
                    end
                end else begin
                    p.d = m_mem[idx];
                end
                m_q.push_back(p);
            end
        end
        m_cyc++;
    endtask

    // One clock: drive at the falling edge, compare shortly after, advance the model.
    task automatic step(input vec_t v, input logic rb, input logic wb,
                        input logic [31:0] ab, input logic [31:0] wdb);
        @(negedge clk);
        rst = v.rst; req = v.req; wr = v.wr; addr = v.addr; strb = v.strb;
        wdata = v.wd; stall = v.stall; block = v.block; size = 2'($urandom_range(0, 3));
        req_b = rb; wr_b = wb; addr_b = ab; wdata_b = wdb;
        #1;
        model_eval(v);
        chk("model_addr_ok", 32'(aok), 32'(m_aok));
        chk("model_data_ok", 32'(dok), 32'(m_dok));
        chk("model_rdata", rdata, m_rd);
        model_update(v);
    endtask

    vec_t vecs[$];
    vec_t idle;
    vec_t rv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; m_cyc = 0; m_last = 32'h0;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; strb = '0;
        wdata = '0; stall = 1'b0; block = 1'b0;
        req_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
        idle = mk(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);

        //          rst req wr addr          strb  wdata         stl blk aok dok rdata
        vecs.push_back(mk(1, 1, 0, 32'h10,   4'h0, 32'h0,        0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 32'h20,   4'hF, 32'h11223344, 0, 0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 32'h20,   4'h2, 32'h0000AB00, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h20,   4'h0, 32'h0,        0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'h1122AB44));
        vecs.push_back(mk(0, 1, 1, 32'h1000, 4'hF, 32'h5A5A5A5A, 0, 0, 1, 0, 32'h1122AB44));
        vecs.push_back(mk(0, 1, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        0, 1, 0, 0, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 1, 32'h10,   4'h0, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        1, 0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h20,   4'h0, 32'h0,        1, 0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h0,    4'h0, 32'h0,        1, 0, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'h1122AB44));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 0, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        1, 0, 1, 0, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 0, 32'h20,   4'h0, 32'h0,        1, 0, 1, 0, 32'h5A5A5A5A));
        vecs.push_back(mk(1, 1, 0, 32'h0,    4'h0, 32'h0,        0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h10,   4'h0, 32'h0,        0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF));

        // Directed vector table on the LATENCY=1 instance.
        foreach (vecs[i]) begin
            step(vecs[i], 1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("row%0d_addr_ok", i), 32'(aok), 32'(vecs[i].aok));
            chk($sformatf("row%0d_data_ok", i), 32'(dok), 32'(vecs[i].dok));
            chk($sformatf("row%0d_rdata", i), rdata, vecs[i].rd);
        end

        // LATENCY=3 instance: write then read, data_ok exactly three cycles after handshake.
        step(idle, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
        chk("lat3_wr_addr_ok", 32'(aok_b), 32'd1);
        chk("lat3_wr_c0", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_wr_c1", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_wr_c2", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_wr_c3", 32'(dok_b), 32'd1);
        chk("lat3_wr_rdata", rdata_b, 32'h0);
        step(idle, 1'b1, 1'b0, 32'h40, 32'h0);
        chk("lat3_rd_addr_ok", 32'(aok_b), 32'd1);
        chk("lat3_rd_c0", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_rd_c1", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_rd_c2", 32'(dok_b), 32'd0);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_rd_c3", 32'(dok_b), 32'd1);
        chk("lat3_rd_rdata", rdata_b, 32'hCAFEF00D);
        step(idle, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_rd_c4", 32'(dok_b), 32'd0);

        // Give words 0..15 known contents before random reads.
        for (int w = 0; w < 16; w++) begin
            rv = mk(0, 1, 1, 32'(w) << 2, 4'hF, $urandom, 0, 0, 0, 0, 32'h0);
            step(rv, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        for (int k = 0; k < 4; k++) step(idle, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic with wrapped upper address bits, stalls, blocks and resets.
        for (int n = 0; n < 3000; n++) begin
            rv.rst   = ($urandom_range(0, 63) == 0);
            rv.req   = ($urandom_range(0, 9) < 7);
            rv.wr    = ($urandom_range(0, 9) < 4);
            rv.addr  = {26'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rv.strb  = 4'($urandom_range(0, 15));
            rv.wd    = $urandom;
            rv.stall = ($urandom_range(0, 3) == 0);
            rv.block = ($urandom_range(0, 6) == 0);
            step(rv, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
